// File: rtl/seq_shift_add_mult.sv
// Iterative shift-add multiplier: B partial-product rows per cycle, N+M-bit product, valid/ready in and out.
// Optional macro SIGNED_MULT_EN adds the tc input for two's-complement operands.
module seq_shift_add_mult #(
  parameter int N = 16,
  parameter int M = 16,
  parameter int B = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   a,
  input  logic [M-1:0]   b,
`ifdef SIGNED_MULT_EN
  input  logic           tc,
`endif
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N+M-1:0] p,
  output logic           busy
);

  localparam int W  = N + M;
  localparam int K  = M / B;
  localparam int CW = (K > 1) ? $clog2(K) : 1;
  localparam logic [CW-1:0] LAST = CW'(K - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // Handshakes: a transfer happens on an edge where valid and ready are both high.
  // in_ready is high only in IDLE, out_valid only in DONE; both come straight from state.
  logic [1:0]    state_q, state_d;
  logic [W-1:0]  a_q, a_d;
  logic [M-1:0]  b_q, b_d;
  logic [W-1:0]  acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  p_q, p_d;
  logic [W-1:0]  sum;
  logic [W-1:0]  row;
  logic          last;
`ifdef SIGNED_MULT_EN
  logic          tc_q, tc_d;
`endif

  // a_q is pre-shifted by B each cycle and b_q shifted right, so row r of this cycle is b_q[r] ? a_q << r.
  always_comb begin
    last = (cnt_q == LAST);
    sum  = acc_q;
    row  = '0;
    for (int r = 0; r < B; r++) begin
      row = b_q[r] ? (a_q << r) : '0;
`ifdef SIGNED_MULT_EN
      if (tc_q && last && (r == B - 1)) sum = sum - row;
      else                              sum = sum + row;
`else
      sum = sum + row;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
`ifdef SIGNED_MULT_EN
    tc_d    = tc_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
`ifdef SIGNED_MULT_EN
          a_d  = (tc && a[N-1]) ? {{M{1'b1}}, a} : {{M{1'b0}}, a};
          tc_d = tc;
`else
          a_d  = {{M{1'b0}}, a};
`endif
          b_d     = b;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        acc_d = sum;
        a_d   = a_q << B;
        b_d   = b_q >> B;
        cnt_d = cnt_q + 1'b1;
        if (last) begin
          p_d     = sum;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      p_q     <= '0;
`ifdef SIGNED_MULT_EN
      tc_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
`ifdef SIGNED_MULT_EN
      tc_q    <= tc_d;
`endif
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q == S_CALC) || (state_q == S_DONE);
  assign p         = p_q;

endmodule

// File: tb/tb_seq_shift_add_mult.sv
// Directed bench for seq_shift_add_mult: a B=1 instance and a B=4 instance side by side.
module tb_seq_shift_add_mult;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] a, b;
  logic        tc;
  logic        in_valid, out_ready, in_ready, out_valid, busy;
  logic [31:0] p;
  logic        in_valid4, out_ready4, in_ready4, out_valid4, busy4;
  logic [31:0] p4;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  seq_shift_add_mult #(.N(16), .M(16), .B(1)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
`ifdef SIGNED_MULT_EN
    .tc(tc),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .p(p), .busy(busy)
  );

  seq_shift_add_mult #(.N(16), .M(16), .B(4)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4), .a(a), .b(b),
`ifdef SIGNED_MULT_EN
    .tc(tc),
`endif
    .out_valid(out_valid4), .out_ready(out_ready4), .p(p4), .busy(busy4)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!out_valid && cyc < 40) begin
      step();
      cyc++;
    end
  endtask

  task automatic accept(input logic [15:0] av, input logic [15:0] bv);
    a = av; b = bv; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  task automatic run_op(input string tag, input logic [15:0] av, input logic [15:0] bv,
                        input logic [31:0] exp_p);
    int cyc;
    out_ready = 1'b1;
    accept(av, bv);
    check({tag, "_in_ready_low"}, in_ready, 1'b0);
    wait_done(cyc);
    check({tag, "_latency"}, cyc, 16);
    check({tag, "_p"}, p, exp_p);
    step();
    check({tag, "_back_idle"}, in_ready, 1'b1);
  endtask

  initial begin
    int cyc;
    int done_at[$];
    logic [31:0] held;
    rst = 1'b1; a = '0; b = '0; tc = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0; in_valid4 = 1'b0; out_ready4 = 1'b0;
    step(); step();
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_p", p, 32'h0);
    check("rst_p4", p4, 32'h0);
    rst = 1'b0;
    step();

    // 3 x 5 with out_ready already high
    run_op("t1", 16'h0003, 16'h0005, 32'h0000_000F);
    check("t1_out_valid_dropped", out_valid, 1'b0);
    check("t1_p_held", p, 32'h0000_000F);

    // max operands, consumer stalls for 10 cycles
    out_ready = 1'b0;
    accept(16'hFFFF, 16'hFFFF);
    check("t2_busy", busy, 1'b1);
    a = 16'h1111; b = 16'h2222;
    wait_done(cyc);
    check("t2_latency", cyc, 16);
    check("t2_p", p, 32'hFFFE_0001);
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      check("t2_hold_valid", out_valid, 1'b1);
      check("t2_hold_p", p, 32'hFFFE_0001);
      check("t2_hold_in_ready", in_ready, 1'b0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    check("t2_idle", in_ready, 1'b1);
    check("t2_p_after", p, 32'hFFFE_0001);
    step();
    check("t2_no_extra_accept", busy, 1'b0);

    // zero operands still take the full 16 cycles
    run_op("t3a", 16'h0000, 16'h1234, 32'h0);
    run_op("t3b", 16'h1234, 16'h0000, 32'h0);

    // reset mid-calculation
    out_ready = 1'b1;
    accept(16'h00FF, 16'h00FF);
    for (int i = 0; i < 7; i++) step();
    check("t5_busy_before_rst", busy, 1'b1);
    rst = 1'b1;
    #1;
    check("t5_rst_out_valid", out_valid, 1'b0);
    check("t5_rst_p", p, 32'h0);
    check("t5_rst_in_ready", in_ready, 1'b1);
    check("t5_rst_busy", busy, 1'b0);
    step();
    rst = 1'b0;
    run_op("t5_after", 16'h0002, 16'h0003, 32'h0000_0006);

    // B=4: 4-cycle latency and back-to-back throughput of one product per 6 cycles
    a = 16'hABCD; b = 16'h1357;
    out_ready4 = 1'b1;
    in_valid4 = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (out_valid4) begin
        done_at.push_back(i);
        check("t4_p", p4, 32'h0CFA_99AB);
      end
    end
    in_valid4 = 1'b0;
    check("t4_count", done_at.size(), 3);
    if (done_at.size() >= 3) begin
      check("t4_latency", done_at[0], 5);
      check("t4_period1", done_at[1] - done_at[0], 6);
      check("t4_period2", done_at[2] - done_at[1], 6);
    end
    held = p4;
    for (int i = 0; i < 10; i++) step();
    check("t4_final_idle", in_ready4, 1'b1);
    check("t4_p_held", p4, 32'h0CFA_99AB);

`ifdef SIGNED_MULT_EN
    tc = 1'b1;
    run_op("t6_neg1sq", 16'hFFFF, 16'hFFFF, 32'h0000_0001);
    run_op("t6_minsx1", 16'h8000, 16'h0001, 32'hFFFF_8000);
    tc = 1'b0;
    run_op("t6_unsigned", 16'h8000, 16'h0001, 32'h0000_8000);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
